// File: rtl/axil_pkg.sv
// Shared AXI-Lite slave definitions: response codes and write-channel FSM states.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    WAIT_AW,
    LOCAL_WR,
    RESP
  } axils_wr_state_t;

endpackage

// File: rtl/axils_addr_dec.sv
// Address window decoder: hit when addr lies in [BASE_ADDR, BASE_ADDR+ADDR_SIZE).
module axils_addr_dec #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0000_1000
) (
  input  logic [31:0] addr,
  output logic        hit
);

  logic [31:0] offset;

  // Offset compare avoids overflow of BASE_ADDR+ADDR_SIZE at the top of the map
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (addr >= BASE_ADDR) && (offset < ADDR_SIZE);
  end

endmodule

// File: rtl/axils_wr.sv
// AXI-Lite slave write channel bridging AW/W/B onto a simple local write port.
// Optional macro AXILS_WR_ADDR_CHECK_EN: out-of-window addresses get DECERR
// without a local write.
module axils_wr_ch
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0000_1000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  output logic        USR_WE,
  output logic [31:0] USR_ADDR,
  output logic [31:0] USR_WDATA,
  output logic [3:0]  USR_WSTB,
  input  logic        USR_WACK,
  input  logic        USR_WERR
);

  axils_wr_state_t state_q, state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  resp_t       bresp_q, bresp_d;
  logic        usr_we_q, usr_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstb_q, wstb_d;

  logic aw_hs, w_hs, launch, addr_ok;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;

`ifdef AXILS_WR_ADDR_CHECK_EN
  logic [31:0] dec_addr;
  logic        unused_ok;
  // Decode the address completing now, or the one already captured
  assign dec_addr  = aw_hs ? AWADDR : addr_q;
  assign unused_ok = ^AWPROT;

  axils_addr_dec #(
    .BASE_ADDR(BASE_ADDR),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_addr_dec (
    .addr(dec_addr),
    .hit (addr_ok)
  );
`else
  logic unused_ok;
  assign addr_ok   = 1'b1;
  assign unused_ok = ^{AWPROT, BASE_ADDR, ADDR_SIZE};
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    usr_we_d  = usr_we_q;
    addr_d    = aw_hs ? AWADDR : addr_q;
    wdata_d   = w_hs ? WDATA : wdata_q;
    wstb_d    = w_hs ? WSTRB : wstb_q;
    launch    = 1'b0;

    unique case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && w_hs) begin
          launch = 1'b1;
        end else if (aw_hs) begin
          state_d   = WAIT_W;
          awready_d = 1'b0;
        end else if (w_hs) begin
          state_d  = WAIT_AW;
          wready_d = 1'b0;
        end
      end
      WAIT_W:  launch = w_hs;
      WAIT_AW: launch = aw_hs;
      LOCAL_WR: begin
        if (USR_WACK) begin
          usr_we_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = USR_WERR ? SLVERR : OKAY;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Both halves present: start the local write, or answer DECERR directly
    if (launch) begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      if (addr_ok) begin
        usr_we_d = 1'b1;
        state_d  = LOCAL_WR;
      end else begin
        bvalid_d = 1'b1;
        bresp_d  = DECERR;
        state_d  = RESP;
      end
    end
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      usr_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstb_q    <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      usr_we_q  <= usr_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstb_q    <= wstb_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign USR_WE    = usr_we_q;
  assign USR_ADDR  = addr_q;
  assign USR_WDATA = wdata_q;
  assign USR_WSTB  = wstb_q;

endmodule

// File: tb/tb_axils_wr_ch.sv
// Testbench for axils_wr_ch: vector table of write transactions plus reset corner cases.
module tb_axils_wr_ch;
  import axil_pkg::*;

`ifdef AXILS_WR_ADDR_CHECK_EN
  localparam logic [31:0] TB_BASE = 32'h0000_1000;
  localparam bit          TB_CHK  = 1'b1;
`else
  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam bit          TB_CHK  = 1'b0;
`endif
  localparam logic [31:0] TB_SIZE = 32'h0000_1000;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        USR_WE;
  logic [31:0] USR_ADDR;
  logic [31:0] USR_WDATA;
  logic [3:0]  USR_WSTB;
  logic        USR_WACK = 1'b0;
  logic        USR_WERR = 1'b0;

  axils_wr_ch #(
    .BASE_ADDR(TB_BASE),
    .ADDR_SIZE(TB_SIZE)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWADDR   (AWADDR),
    .AWPROT   (AWPROT),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .USR_WE   (USR_WE),
    .USR_ADDR (USR_ADDR),
    .USR_WDATA(USR_WDATA),
    .USR_WSTB (USR_WSTB),
    .USR_WACK (USR_WACK),
    .USR_WERR (USR_WERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          ack_dly;
    logic        werr;
    int          b_dly;
    bit          stray_ack;
    bit          extra_aw;
    logic [1:0]  exp_resp;
    int          exp_we_cyc;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } lw_t;

  lw_t        exp_lw_q[$];
  logic [1:0] exp_b_q[$];
  vec_t       vecs[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the B response for one write
  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic werr);
    logic out_of_win;
    out_of_win = (a < TB_BASE) || ((a - TB_BASE) >= TB_SIZE);
    if (TB_CHK && out_of_win) return 2'b11;
    return werr ? 2'b10 : 2'b00;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int awd, input int wd, input int ackd, input logic werr,
                              input int bd, input bit stray, input bit xaw);
    vec_t v;
    v.addr = a; v.data = d; v.strb = s;
    v.aw_dly = awd; v.w_dly = wd; v.ack_dly = ackd; v.werr = werr;
    v.b_dly = bd; v.stray_ack = stray; v.extra_aw = xaw;
    v.exp_resp   = model_resp(a, werr);
    v.exp_we_cyc = (v.exp_resp == 2'b11) ? 0 : ackd + 1;
    v.exp_lat    = (v.exp_resp == 2'b11) ? 1 : ackd + 2;
    return v;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic run_vec(input vec_t v);
    bit         aw_pend, w_pend, hs_aw, hs_w, b_done;
    int         cyc, lat, we_cnt;
    lw_t        lw;
    logic [1:0] eb;

    if (v.exp_resp != 2'b11) exp_lw_q.push_back('{v.addr, v.data, v.strb});
    exp_b_q.push_back(v.exp_resp);

    AWADDR = v.addr; WDATA = v.data; WSTRB = v.strb; AWPROT = 3'b101;
    aw_pend = 1'b1; w_pend = 1'b1; cyc = 0;
    while ((aw_pend || w_pend) && cyc < 50) begin
      AWVALID  = aw_pend && (cyc >= v.aw_dly);
      WVALID   = w_pend && (cyc >= v.w_dly);
      USR_WACK = v.stray_ack;
      USR_WERR = v.stray_ack;
      if (!aw_pend) check("awready_low_wait_w", AWREADY, 0);
      if (!w_pend)  check("wready_low_wait_aw", WREADY, 0);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      tick();
      if (hs_aw) aw_pend = 1'b0;
      if (hs_w)  w_pend  = 1'b0;
      cyc++;
    end
    AWVALID = 1'b0; WVALID = 1'b0; USR_WACK = 1'b0; USR_WERR = 1'b0;
    if (aw_pend || w_pend) check("handshake_timeout", 1, 0);

    lat = 1; we_cnt = 0;
    while (!BVALID && lat < 60) begin
      if (USR_WE) begin
        check("ready_low_local_wr", {AWREADY, WREADY}, 0);
        USR_WACK = (we_cnt == v.ack_dly);
        USR_WERR = v.werr;
        if (USR_WACK) begin
          if (exp_lw_q.size() == 0) begin
            check("local_write_unexpected", 1, 0);
          end else begin
            lw = exp_lw_q.pop_front();
            check("usr_addr", USR_ADDR, lw.addr);
            check("usr_wdata", USR_WDATA, lw.data);
            check("usr_wstb", USR_WSTB, lw.strb);
          end
        end
        we_cnt++;
      end else begin
        USR_WACK = 1'b0;
      end
      tick();
      lat++;
    end
    USR_WACK = 1'b0; USR_WERR = 1'b0;
    check("bvalid_seen", BVALID, 1);
    check("bvalid_latency", lat, v.exp_lat);
    check("usr_we_cycles", we_cnt, v.exp_we_cyc);
    check("usr_we_low_in_resp", USR_WE, 0);

    b_done = 1'b0;
    for (int k = 0; k < 40 && !b_done; k++) begin
      BREADY  = (k >= v.b_dly);
      AWVALID = v.extra_aw && !BREADY;
      if (v.extra_aw) AWADDR = 32'h0000_0BAD;
      check("bvalid_hold", BVALID, 1);
      check("bresp_hold", BRESP, v.exp_resp);
      if (v.extra_aw) check("aw_blocked_in_resp", AWREADY, 0);
      if (BREADY) begin
        eb = exp_b_q.pop_front();
        check("bresp_scoreboard", BRESP, eb);
        b_done = 1'b1;
      end
      tick();
    end
    BREADY = 1'b0; AWVALID = 1'b0;
    check("b_done_idle", {BVALID, AWREADY, WREADY}, 3'b011);
    check("usr_addr_held", USR_ADDR, v.addr);
    check("usr_wdata_held", USR_WDATA, v.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0000_0020, 32'h1234_5678, 4'h3, 3, 0, 0, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0030, 32'hA5A5_5A5A, 4'hF, 0, 0, 5, 1'b1, 0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0040, 32'h0BAD_F00D, 4'hC, 0, 0, 1, 1'b0, 4, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0044, 32'h1111_1111, 4'h0, 1, 2, 0, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0048, 32'hCAFE_0001, 4'h9, 0, 2, 2, 1'b0, 1, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0000_0FFC, 32'h0000_0FFC, 4'hF, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_1000, 32'h0000_1000, 4'hF, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_1FFC, 32'h7777_8888, 4'h6, 0, 0, 1, 1'b1, 2, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_2000, 32'h9999_AAAA, 4'hF, 2, 0, 0, 1'b0, 0, 1'b0, 1'b0));

    // Reset values
    repeat (2) @(negedge ACLK);
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_usr_we", USR_WE, 0);
    check("rst_usr_addr", USR_ADDR, 0);
    check("rst_usr_wdata", USR_WDATA, 0);
    check("rst_usr_wstb", USR_WSTB, 0);
    ARESETn = 1'b1;
    #1 check("rdy_before_first_edge", {AWREADY, WREADY}, 0);
    @(negedge ACLK);
    check("rdy_after_first_edge", {AWREADY, WREADY}, 2'b11);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during LOCAL_WR aborts the write with no response
    AWADDR = 32'h0000_0050; WDATA = 32'h5555_AAAA; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; USR_WACK = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check("abort_usr_we_before", USR_WE, 1);
    @(posedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    check("abort_usr_we", USR_WE, 0);
    check("abort_bvalid", BVALID, 0);
    check("abort_ready", {AWREADY, WREADY}, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1 check("abort_rdy_before_edge", {AWREADY, WREADY}, 0);
    @(negedge ACLK);
    check("abort_rdy_after_edge", {AWREADY, WREADY}, 2'b11);
    USR_WACK = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_we_no_b", {USR_WE, BVALID}, 0);
    end
    USR_WACK = 1'b0;

    check("scoreboard_empty", exp_lw_q.size() + exp_b_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
